// File: rtl/ray_request_issuer.sv
// Raster-order pixel request issuer for the ray generator: one request per ISSUE+GAP pair, held while gen_ready_in is low.
// Optional field-interlaced frames are enabled by defining RAY_ISSUER_INTERLACE_EN.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 4
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 2
`endif
`ifndef H_BITS
`define H_BITS 2
`endif
`ifndef V_BITS
`define V_BITS 2
`endif
`ifndef FP_WIDTH
`define FP_WIDTH 16
`endif
`ifndef FP_FRAC
`define FP_FRAC 8
`endif
`ifndef FP_INV_DISPLAY_HEIGHT
`define FP_INV_DISPLAY_HEIGHT ((1 << `FP_FRAC) / DISPLAY_HEIGHT)
`endif

module ray_request_issuer #(
  parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int H_BITS         = `H_BITS,
  parameter int V_BITS         = `V_BITS
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic [3*`FP_WIDTH-1:0]       cam_forward_in,
  input  logic                         gen_ready_in,
  input  logic                         gen_valid_in,
  output logic                         valid_out,
  output logic [H_BITS-1:0]            hcount_out,
  output logic [V_BITS-1:0]            vcount_out,
  output logic signed [`FP_WIDTH-1:0]  hcount_fp_out,
  output logic signed [`FP_WIDTH-1:0]  vcount_fp_out,
  output logic [3*`FP_WIDTH-1:0]       cam_forward_out,
  output logic                         busy_out,
  output logic                         frame_done_out
);

  localparam int FP_W    = `FP_WIDTH;
  localparam int TOTAL   = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int CNT_W   = $clog2(TOTAL + 1);
  localparam int INV_H_I = `FP_INV_DISPLAY_HEIGHT;
  localparam logic signed [FP_W-1:0] STEP = FP_W'(INV_H_I << 1);
  localparam logic signed [FP_W-1:0] PX0  = FP_W'(-(DISPLAY_WIDTH * INV_H_I));
  localparam logic signed [FP_W-1:0] PY0  = FP_W'(-(DISPLAY_HEIGHT * INV_H_I));
`ifdef RAY_ISSUER_INTERLACE_EN
  localparam int V_STEP = 2;
  localparam logic [CNT_W-1:0] TOTAL_EVEN = CNT_W'(((DISPLAY_HEIGHT + 1) / 2) * DISPLAY_WIDTH);
  localparam logic [CNT_W-1:0] TOTAL_ODD  = CNT_W'((DISPLAY_HEIGHT / 2) * DISPLAY_WIDTH);
`else
  localparam int V_STEP = 1;
`endif
  localparam logic signed [FP_W-1:0] PY_STEP = FP_W'(V_STEP * (INV_H_I << 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic signed [FP_W-1:0] fp_add(input logic signed [FP_W-1:0] a,
                                                    input logic signed [FP_W-1:0] b);
    return a + b;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [H_BITS-1:0]       r_h;
  logic [V_BITS-1:0]       r_v;
  logic signed [FP_W-1:0]  r_px;
  logic signed [FP_W-1:0]  r_py;
  logic [3*FP_W-1:0]       r_cam;
  logic [CNT_W-1:0]        r_issued;
  logic [CNT_W-1:0]        r_returned;
  logic [CNT_W-1:0]        w_total;
  logic [CNT_W-1:0]        w_ret_nxt;
  logic                    w_xfer;
  logic                    w_ret_en;
  logic                    w_last;
  logic                    w_row_end;
  logic                    w_start;
`ifdef RAY_ISSUER_INTERLACE_EN
  logic                    r_field;
`endif

`ifdef RAY_ISSUER_INTERLACE_EN
  assign w_total = r_field ? TOTAL_ODD : TOTAL_EVEN;
`else
  assign w_total = CNT_W'(TOTAL);
`endif

  assign w_start   = (r_state == S_IDLE) && start_in;
  assign w_xfer    = (r_state == S_ISSUE) && gen_ready_in;
  assign w_ret_en  = gen_valid_in && (r_state inside {S_ISSUE, S_GAP, S_DRAIN});
  assign w_ret_nxt = w_ret_en ? r_returned + CNT_W'(1) : r_returned;
  assign w_last    = (r_issued == w_total - CNT_W'(1));
  assign w_row_end = (r_h == H_BITS'(DISPLAY_WIDTH - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    valid_out      = 1'b0;
    busy_out       = 1'b1;
    frame_done_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        valid_out = 1'b1;
        if (w_xfer) w_state_nxt = w_last ? S_DRAIN : S_GAP;
      end
      S_GAP: begin
        w_state_nxt = S_ISSUE;
      end
      // Use the post-increment count so a return on this edge ends DRAIN immediately.
      S_DRAIN: begin
        if (w_ret_nxt >= w_total) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        frame_done_out = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        busy_out    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_h        <= '0;
      r_v        <= '0;
      r_px       <= PX0;
      r_py       <= PY0;
      r_cam      <= '0;
      r_issued   <= '0;
      r_returned <= '0;
`ifdef RAY_ISSUER_INTERLACE_EN
      r_field    <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_cam      <= cam_forward_in;
        r_h        <= '0;
        r_px       <= PX0;
        r_issued   <= '0;
        r_returned <= '0;
`ifdef RAY_ISSUER_INTERLACE_EN
        r_v        <= V_BITS'(r_field);
        r_py       <= r_field ? fp_add(PY0, STEP) : PY0;
`else
        r_v        <= '0;
        r_py       <= PY0;
`endif
      end else begin
        if (w_ret_en) r_returned <= w_ret_nxt;
        if (w_xfer) begin
          r_issued <= r_issued + CNT_W'(1);
          // Row wrap reloads px from the constant so rounding never accumulates across rows.
          if (w_row_end) begin
            r_h  <= '0;
            r_px <= PX0;
            r_v  <= r_v + V_BITS'(V_STEP);
            r_py <= fp_add(r_py, PY_STEP);
          end else begin
            r_h  <= r_h + H_BITS'(1);
            r_px <= fp_add(r_px, STEP);
          end
        end
      end
`ifdef RAY_ISSUER_INTERLACE_EN
      if (r_state == S_DONE) r_field <= ~r_field;
`endif
    end
  end

  assign hcount_out      = r_h;
  assign vcount_out      = r_v;
  assign hcount_fp_out   = r_px;
  assign vcount_fp_out   = r_py;
  assign cam_forward_out = r_cam;

endmodule
